// File: rtl/mul_share_pkg.sv
// Shared types and parameter defaults for the multiplier-sharing
// scheduler.
package mul_share_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int N_DEF    = 16;
   localparam int NREQ_DEF = 4;
   localparam int IDW_DEF  = 2;
   localparam int CW_DEF   = 16;

endpackage

// File: rtl/mul_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request at or after
// the pointer, wrapping around.
module rr_pick
   import mul_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  win,
   output logic            any
);

   // Scan downward so the candidate closest to the pointer wins last.
   always_comb begin
      int idx;
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            any = 1'b1;
            win = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin front end that shares one sequential multiplier
// between several requesters and returns tagged products.
module mul_share_ctrl
   import mul_share_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0] gnt,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IDW-1:0]  rsp_id,
   output logic [2*N-1:0]  rsp_y,
   output logic            mul_start,
   output logic [N-1:0]    mul_ain,
   output logic [N-1:0]    mul_bin,
   input  logic            mul_done,
   input  logic [2*N-1:0]  mul_yout,
   output logic            busy,
   output logic [CW-1:0]   op_count
);

   state_t          state;
   state_t          nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  win;
   logic [IDW-1:0]  pick_win;
   logic            pick_any;
   logic [N-1:0]    op_a;
   logic [N-1:0]    op_b;
   logic [2*N-1:0]  y;
   logic [CW-1:0]   cnt;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .win (pick_win),
      .any (pick_any)
   );

   // State register.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) state <= IDLE;
      else         state <= nxt;
   end

   // Next-state and handshake pulses.
   always_comb begin
      nxt       = state;
      gnt       = '0;
      mul_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_any) nxt = ISSUE;
         end
         ISSUE: begin
            gnt[win]  = 1'b1;
            mul_start = 1'b1;
            nxt       = WAIT;
         end
         WAIT: begin
            if (mul_done) nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Winner/operand capture, product capture, pointer and counter.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         win  <= '0;
         op_a <= '0;
         op_b <= '0;
         y    <= '0;
         ptr  <= '0;
         cnt  <= '0;
      end else begin
         if (state == IDLE && pick_any) begin
            win  <= pick_win;
            op_a <= req_a[pick_win*N +: N];
            op_b <= req_b[pick_win*N +: N];
         end
         if (state == WAIT && mul_done) y <= mul_yout;
         if (state == RESP && rsp_ready) begin
            cnt <= cnt + 1'b1;
            ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign rsp_id    = win;
   assign rsp_y     = y;
   assign mul_ain   = op_a;
   assign mul_bin   = op_b;
   assign busy      = (state != IDLE);
   assign op_count  = cnt;

endmodule
